// File: rtl/trickbox_mc.sv
// trickbox_mc: simulation helper on the data-memory bus.
// It provides a scaled 64-bit time counter, per-channel line-buffered
// consoles, a down-counting timer with a sticky interrupt, and an exit port.
// Console text is emitted only when TRICKBOX_NO_PRINT is left undefined.
module trickbox_mc #(
  parameter int                    ADDR_WIDTH        = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = 32'hAAAA0000,
  parameter int                    NUM_CHAN          = 2,
  parameter int                    LINE_DEPTH        = 80,
  parameter int                    TIME_SCALE_FACTOR = 10,
  parameter bit                    FLUSH_ON_NL       = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  taken,
  output logic                  irq,
  output logic                  sim_done,
  output logic [31:0]           exit_code
);

  localparam int PW  = (TIME_SCALE_FACTOR > 1) ? $clog2(TIME_SCALE_FACTOR) : 1;
  localparam int LW  = $clog2(LINE_DEPTH + 1);
  localparam int IW  = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam int CIW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  // Time base
  logic [PW-1:0]  presc;
  logic [63:0]    time64;
  logic [31:0]    hi_shadow;
  logic           tick;

  // Timer
  logic [31:0]    tmr_count;
  logic [31:0]    tmr_reload;
  logic           tmr_en;
  logic           tmr_per;
  logic           tmr_dec;
  logic           tmr_exp;

  // Consoles
  logic [7:0]     line_buf [NUM_CHAN][LINE_DEPTH];
  logic [LW-1:0]  level [NUM_CHAN];
  logic [NUM_CHAN-1:0] ovf;

  // Decode
  logic [ADDR_WIDTH-1:0] off;
  logic [8:0]     lo;
  logic           in_range;
  logic [2:0]     cidx;
  logic [CIW-1:0] ci;
  logic [CIW-1:0] putc_idx;
  logic           chan_ok;
  logic           hit_tlo, hit_thi, hit_alias, hit_load, hit_ctrl, hit_exit;
  logic           hit_chput, hit_stat;
  logic           rd, wr, rd_ok, wr_ok;
  logic           do_putc, do_exit;
  logic [7:0]     ch_char;
  logic           ch_flush;

  assign off      = addr - BASE_ADDR;
  assign lo       = off[8:0];
  assign in_range = (off[ADDR_WIDTH-1:9] == '0);
  assign cidx     = lo[6:4];
  assign ci       = cidx[CIW-1:0];

  // Address decode, direction legality and read-beats-write arbitration
  always_comb begin
    chan_ok   = in_range && lo[8] && !lo[7] && (int'(cidx) < NUM_CHAN);
    hit_tlo   = in_range && (lo == 9'h000);
    hit_thi   = in_range && (lo == 9'h004);
    hit_alias = in_range && (lo == 9'h008);
    hit_load  = in_range && (lo == 9'h010);
    hit_ctrl  = in_range && (lo == 9'h014);
    hit_exit  = in_range && (lo == 9'h018);
    hit_chput = chan_ok && (lo[3:0] == 4'h0);
    hit_stat  = chan_ok && (lo[3:0] == 4'h4);
    rd        = read;
    wr        = write && !read;
    rd_ok     = rd && (hit_tlo || hit_thi || hit_load || hit_ctrl || hit_stat);
    wr_ok     = wr && (hit_alias || hit_chput || hit_load || hit_ctrl || hit_exit);
    taken     = rd_ok || wr_ok;
    do_putc   = wr_ok && (hit_alias || hit_chput);
    do_exit   = wr_ok && hit_exit;
    putc_idx  = hit_alias ? '0 : ci;
    ch_char   = data_in[7:0];
    ch_flush  = (ch_char == 8'h00) || (FLUSH_ON_NL && (ch_char == 8'h0A));
    tick      = (presc == PW'(TIME_SCALE_FACTOR - 1));
    tmr_dec   = tick && tmr_en && (tmr_count != 32'd0);
    tmr_exp   = tmr_dec && (tmr_count == 32'd1);
  end

  // Read data mux; zero whenever the access is not a legal read
  always_comb begin
    data_out = '0;
    if (rd_ok) begin
      if (hit_tlo)       data_out = time64[31:0];
      else if (hit_thi)  data_out = hi_shadow;
      else if (hit_load) data_out = tmr_count;
      else if (hit_ctrl) data_out = {30'b0, tmr_per, tmr_en};
      else               data_out = 32'(level[ci]) | (32'(ovf[ci]) << 16);
    end
  end

`ifndef TRICKBOX_NO_PRINT
  task automatic show(input int c);
    string s;
    s = "";
    for (int i = 0; i < int'(level[c]); i++) s = $sformatf("%s%c", s, line_buf[c][i]);
    $display("trickbox[%0d]: %s%s", c, s, ovf[c] ? " [overflow]" : "");
  endtask
`endif

  // Time counter, TIME_HI shadow capture and timer with sticky interrupt
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      time64     <= '0;
      hi_shadow  <= '0;
      tmr_count  <= '0;
      tmr_reload <= '0;
      tmr_en     <= 1'b0;
      tmr_per    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (tick) begin
        presc  <= '0;
        time64 <= time64 + 64'd1;
      end else begin
        presc  <= presc + PW'(1);
      end
      if (rd_ok && hit_tlo) hi_shadow <= time64[63:32];
      if (tmr_dec) begin
        tmr_count <= tmr_count - 32'd1;
        if (tmr_exp) begin
          if (tmr_per) tmr_count <= tmr_reload;
          else         tmr_en    <= 1'b0;
        end
      end
      // Bus writes override the same-edge countdown update
      if (wr_ok && hit_load) begin
        tmr_reload <= data_in;
        tmr_count  <= data_in;
      end
      if (wr_ok && hit_ctrl) begin
        tmr_en  <= data_in[0];
        tmr_per <= data_in[1];
      end
      // An expiry on the same edge as IRQ_CLR keeps the interrupt raised
      if (tmr_exp)                              irq <= 1'b1;
      else if (wr_ok && hit_ctrl && data_in[2]) irq <= 1'b0;
    end
  end

  // Console line buffers, flushes and the exit port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        level[c] <= '0;
        for (int i = 0; i < LINE_DEPTH; i++) line_buf[c][i] <= '0;
      end
      ovf       <= '0;
      sim_done  <= 1'b0;
      exit_code <= '0;
    end else begin
      if (do_putc) begin
        if (ch_flush) begin
`ifndef TRICKBOX_NO_PRINT
          if ((level[putc_idx] != '0) || ovf[putc_idx]) show(int'(putc_idx));
`endif
          level[putc_idx] <= '0;
          ovf[putc_idx]   <= 1'b0;
        end else if (level[putc_idx] == LW'(LINE_DEPTH)) begin
          ovf[putc_idx] <= 1'b1;
        end else begin
          line_buf[putc_idx][level[putc_idx][IW-1:0]] <= ch_char;
          level[putc_idx] <= level[putc_idx] + LW'(1);
        end
      end
      if (do_exit) begin
        exit_code <= data_in;
        sim_done  <= 1'b1;
        for (int c = 0; c < NUM_CHAN; c++) begin
          if ((level[c] != '0) || ovf[c]) begin
`ifndef TRICKBOX_NO_PRINT
            show(c);
`endif
            level[c] <= '0;
            ovf[c]   <= 1'b0;
          end
        end
`ifndef TRICKBOX_NO_PRINT
        $display("trickbox: exit %0d", data_in);
`endif
      end
    end
  end

endmodule

// File: tb/tb_trickbox_mc.sv
// tb_trickbox_mc: directed scenarios followed by randomized bus traffic,
// checked every cycle against a register-level behavioural model.
module tb_trickbox_mc;

  localparam int          NCH   = 2;
  localparam int          DEPTH = 4;
  localparam int          TSF   = 10;
  localparam logic [31:0] BASE  = 32'hAAAA0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        taken;
  logic        irq;
  logic        sim_done;
  logic [31:0] exit_code;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_dout;
  logic        last_taken;

  // Behavioural model state
  longint unsigned m_n;
  logic [31:0]     m_hi;
  int              m_lvl [NCH];
  bit              m_ovf [NCH];
  logic [31:0]     m_cnt, m_rel, m_code;
  bit              m_en, m_per, m_irq, m_done;

  trickbox_mc #(
    .ADDR_WIDTH(32), .BASE_ADDR(BASE), .NUM_CHAN(NCH), .LINE_DEPTH(DEPTH),
    .TIME_SCALE_FACTOR(TSF), .FLUSH_ON_NL(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .read(read), .write(write),
    .data_in(data_in), .data_out(data_out), .taken(taken), .irq(irq),
    .sim_done(sim_done), .exit_code(exit_code)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_hi = '0; m_cnt = '0; m_rel = '0; m_code = '0;
    m_en = 0; m_per = 0; m_irq = 0; m_done = 0;
    for (int c = 0; c < NCH; c++) begin m_lvl[c] = 0; m_ovf[c] = 0; end
  endtask

  function automatic logic [63:0] m_time();
    return 64'(m_n / TSF);
  endfunction

  // Expected bus response from the register map
  task automatic expect_bus(input logic r, input logic w, input logic [31:0] a,
                            output logic tk, output logic [31:0] dv);
    logic [31:0] o;
    logic [63:0] t;
    o = a - BASE; t = m_time(); tk = 1'b0; dv = '0;
    if (r) begin
      tk = 1'b1;
      case (o)
        32'h000: dv = t[31:0];
        32'h004: dv = m_hi;
        32'h010: dv = m_cnt;
        32'h014: dv = {30'b0, m_per, m_en};
        32'h104: dv = {15'b0, m_ovf[0], 16'(m_lvl[0])};
        32'h114: dv = {15'b0, m_ovf[1], 16'(m_lvl[1])};
        default: tk = 1'b0;
      endcase
    end else if (w) begin
      tk = (o == 32'h008) || (o == 32'h010) || (o == 32'h014) || (o == 32'h018) ||
           (o == 32'h100) || (o == 32'h110);
    end
  endtask

  task automatic model_putc(input int c, input logic [7:0] ch);
    if (ch == 8'h00 || ch == 8'h0A) begin m_lvl[c] = 0; m_ovf[c] = 0; end
    else if (m_lvl[c] == DEPTH) m_ovf[c] = 1;
    else m_lvl[c]++;
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] o;
    logic [63:0] t;
    bit tick, expire, clr;
    o = a - BASE; t = m_time(); expire = 0; clr = 0;
    if (r && o == 32'h0) m_hi = t[63:32];
    tick = ((m_n + 1) % TSF) == 0;
    m_n++;
    if (tick && m_en && m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        expire = 1;
        if (m_per) m_cnt = m_rel; else m_en = 0;
      end
    end
    if (w && !r) begin
      if (o == 32'h008 || o == 32'h100) model_putc(0, d[7:0]);
      else if (o == 32'h110) model_putc(1, d[7:0]);
      else if (o == 32'h010) begin m_rel = d; m_cnt = d; end
      else if (o == 32'h014) begin m_en = d[0]; m_per = d[1]; clr = d[2]; end
      else if (o == 32'h018) begin
        m_code = d; m_done = 1;
        for (int c = 0; c < NCH; c++) begin m_lvl[c] = 0; m_ovf[c] = 0; end
      end
    end
    if (expire) m_irq = 1; else if (clr) m_irq = 0;
  endtask

  // One bus cycle: drive at negedge, check before posedge, advance model at posedge
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic tk;
    logic [31:0] dv;
    read = r; write = w; addr = a; data_in = d;
    #2;
    expect_bus(r, w, a, tk, dv);
    last_dout = data_out; last_taken = taken;
    check("taken", taken, tk);
    check("data_out", data_out, dv);
    check("irq", irq, m_irq);
    check("sim_done", sim_done, m_done);
    check("exit_code", exit_code, m_code);
    @(posedge clock);
    model_edge(r, w, a, d);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, BASE + 32'h40, 32'h0);
  endtask

  task automatic wr_reg(input logic [31:0] o, input logic [31:0] d);
    step(1'b0, 1'b1, BASE + o, d);
  endtask

  task automatic rd_reg(input logic [31:0] o);
    step(1'b1, 1'b0, BASE + o, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #2;
    check("rst_irq", irq, 1'b0);
    check("rst_sim_done", sim_done, 1'b0);
    check("rst_exit_code", exit_code, 32'h0);
    check("rst_taken", taken, 1'b0);
    check("rst_data_out", data_out, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int g;
    bit seen;
    logic [31:0] bad [6];
    logic [7:0] chr;
    int op;
    bad = '{32'h00C, 32'h01C, 32'h120, 32'h108, 32'h002, 32'h200};

    do_reset();

    // Scenario 1: time after 95 clocks
    idle(95);
    rd_reg(32'h000);
    check("t1_time_lo", last_dout, 32'd9);
    check("t1_taken_lo", last_taken, 1'b1);
    rd_reg(32'h004);
    check("t1_time_hi", last_dout, 32'd0);
    check("t1_taken_hi", last_taken, 1'b1);

    // Scenario 2: channel 1 line
    wr_reg(32'h110, 32'h68);
    wr_reg(32'h110, 32'h69);
    rd_reg(32'h114);
    check("t2_status1_pre", last_dout, 32'd2);
    rd_reg(32'h104);
    check("t2_status0", last_dout, 32'd0);
    wr_reg(32'h110, 32'h00);
    rd_reg(32'h114);
    check("t2_status1_post", last_dout, 32'd0);

    // Scenario 3: overflow via legacy alias
    for (int i = 0; i < 6; i++) wr_reg(32'h008, 32'h61 + i);
    rd_reg(32'h104);
    check("t3_status0_ovf", last_dout, 32'h0001_0004);
    wr_reg(32'h008, 32'h00);
    rd_reg(32'h104);
    check("t3_status0_clr", last_dout, 32'h0);

    // Scenario 4: periodic timer
    wr_reg(32'h010, 32'd3);
    wr_reg(32'h014, 32'd3);
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin idle(1); if (irq) seen = 1; end
    check("t4_irq_first", irq, 1'b1);
    g = 0;
    rd_reg(32'h010); g++;
    check("t4_reloaded", last_dout, 32'd3);
    wr_reg(32'h014, 32'd7); g++;
    check("t4_irq_cleared", irq, 1'b0);
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin idle(1); g++; if (irq) seen = 1; end
    check("t4_irq_again", irq, 1'b1);
    check("t4_period", g, 30);
    wr_reg(32'h014, 32'd4);
    check("t4_irq_off", irq, 1'b0);

    // Scenario 5: exit with pending text
    wr_reg(32'h008, 32'h61);
    wr_reg(32'h008, 32'h62);
    wr_reg(32'h018, 32'd7);
    check("t5_sim_done", sim_done, 1'b1);
    check("t5_exit_code", exit_code, 32'd7);
    rd_reg(32'h104);
    check("t5_status0", last_dout, 32'd0);

    // Scenario 6: unmapped read and illegal-direction write
    rd_reg(32'h01C);
    check("t6_unmapped_taken", last_taken, 1'b0);
    wr_reg(32'h000, 32'hFFFF);
    check("t6_wr_time_taken", last_taken, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 11);
      case ($urandom_range(0, 9))
        0:       chr = 8'h00;
        1:       chr = 8'h0A;
        default: chr = 8'h61 + 8'($urandom_range(0, 25));
      endcase
      case (op)
        0:  wr_reg(32'h008, {24'($urandom), chr});
        1:  wr_reg(32'h100, {24'h0, chr});
        2:  wr_reg(32'h110, {24'h0, chr});
        3:  rd_reg(32'h104 + 32'h10 * $urandom_range(0, 2));
        4:  rd_reg(32'h000);
        5:  rd_reg(32'h004);
        6:  wr_reg(32'h010, $urandom_range(0, 4));
        7:  wr_reg(32'h014, $urandom_range(0, 7));
        8:  rd_reg($urandom_range(0, 1) ? 32'h010 : 32'h014);
        9:  step($urandom_range(0, 1) ? 1'b1 : 1'b0, 1'b1, BASE + bad[$urandom_range(0, 5)], $urandom);
        10: step(1'b1, 1'b1, BASE + (($urandom_range(0, 2) == 0) ? 32'h010 :
                                     ($urandom_range(0, 1) ? 32'h100 : 32'h018)), $urandom);
        default: idle(1);
      endcase
    end

    // Mid-line reset discards buffered text
    wr_reg(32'h100, 32'h78);
    wr_reg(32'h100, 32'h79);
    do_reset();
    rd_reg(32'h104);
    check("t6_status_after_reset", last_dout, 32'd0);
    check("t6_done_after_reset", sim_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
